fetch_sequencer: RTL and testbench

Instruction fetch and program sequencer for the 8-bit CPU. It walks the program counter and reads 12-bit instruction words from the synchronous program ROM. It presents the 4-bit opcode to the control unit for exactly one decode cycle and the 8-bit operand to the datapath. It resolves unconditional and conditional jumps from the control unit's registered jump/compare signals and the datapath comparator flags. HALT is handled here.

---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/branch_cond.sv | 29 ++
 rtl/fetch_sequencer.sv | 121 ++++++++++++
 tb/tb_fetch_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the 8-bit CPU fetch/sequence path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_LOAD   = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } seqState_e;

  localparam logic [3:0] NOP_OP  = 4'b1111;
  localparam logic [3:0] HALT_OP = 4'b1111;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_LT = 2'b01;
  localparam logic [1:0] CMP_GT = 2'b10;

  localparam int OPC_MSB = 11;
  localparam int OPC_LSB = 8;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  // Compare-select encoding 2'b11 is reserved and never satisfies a condition.
  function automatic logic selectCond(
    input logic [1:0] comp,
    input logic       flagEq,
    input logic       flagLt,
    input logic       flagGt
  );
    logic result;
    result = 1'b0;
    case (comp)
      CMP_EQ:  result = flagEq;
      CMP_LT:  result = flagLt;
      CMP_GT:  result = flagGt;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_cond.sv
// ============================================================================
// Module      : branch_cond
// Description : Combinational jump resolution from control-unit and flag inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_cond
  import cpu_pkg::*;
(
  input  logic       i_jp,
  input  logic       i_jpc,
  input  logic [1:0] i_comp,
  input  logic       i_flagEq,
  input  logic       i_flagLt,
  input  logic       i_flagGt,
  output logic       o_takeJump
);

  logic w_cond;

  assign w_cond = selectCond(i_comp, i_flagEq, i_flagLt, i_flagGt);

  // Unconditional jump dominates the conditional one.
  assign o_takeJump = i_jp | (i_jpc & w_cond);

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module      : fetch_sequencer
// Description : Four-phase instruction fetch / PC sequencer with jump and HALT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int OPND_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [OPC_W+OPND_W-1:0] rom_data,
  output logic [OPC_W-1:0]        op_code,
  output logic [OPND_W-1:0]       operand,
  input  logic                    jp,
  input  logic                    jpc,
  input  logic [1:0]              comp,
  input  logic                    flag_eq,
  input  logic                    flag_lt,
  input  logic                    flag_gt,
  output logic [ADDR_W-1:0]       pc,
  output logic                    halted,
  output logic                    retire
);

  localparam int                c_INSTR_W  = OPC_W + OPND_W;
  localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_PC);

  seqState_e          r_state;
  seqState_e          w_nextState;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_nextPc;
  logic [c_INSTR_W-1:0] r_ir;
  logic               w_loadIr;
  logic [OPC_W-1:0]   w_irOpcode;
  logic [OPND_W-1:0]  w_irOperand;
  logic [ADDR_W-1:0]  w_jumpTarget;
  logic               w_takeJump;

  assign w_irOpcode  = r_ir[OPND_W +: OPC_W];
  assign w_irOperand = r_ir[OPND_W-1:0];

  // Jump target is the operand resized to the PC width.
  if (OPND_W >= ADDR_W) begin : g_truncTarget
    assign w_jumpTarget = w_irOperand[ADDR_W-1:0];
  end else begin : g_extendTarget
    assign w_jumpTarget = {{(ADDR_W - OPND_W){1'b0}}, w_irOperand};
  end

  branch_cond u_branchCond (
    .i_jp       (jp),
    .i_jpc      (jpc),
    .i_comp     (comp),
    .i_flagEq   (flag_eq),
    .i_flagLt   (flag_lt),
    .i_flagGt   (flag_gt),
    .o_takeJump (w_takeJump)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= c_RESET_PC;
      r_ir    <= '0;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_nextPc;
      if (w_loadIr) begin
        r_ir <= rom_data;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextPc    = r_pc;
    w_loadIr    = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        if (run) begin
          w_nextState = S_LOAD;
        end
      end
      S_LOAD: begin
        w_loadIr    = 1'b1;
        w_nextState = S_DECODE;
      end
      S_DECODE: begin
        w_nextState = (w_irOpcode == HALT_OP) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        w_nextPc    = w_takeJump ? w_jumpTarget : r_pc + ADDR_W'(1);
        w_nextState = S_FETCH;
      end
      S_HALT: begin
        w_nextState = S_HALT;
      end
      default: begin
        w_nextState = S_FETCH;
      end
    endcase
  end

  // Opcode is visible only during decode so control strobes last one cycle.
  assign op_code  = (r_state == S_DECODE) ? w_irOpcode : NOP_OP;
  assign operand  = w_irOperand;
  assign rom_addr = r_pc;
  assign pc       = r_pc;
  assign halted   = (r_state == S_HALT);
  assign retire   = (r_state == S_EXEC);

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Scoreboard bench for fetch_sequencer with ROM and control-unit models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  typedef struct packed {
    logic [7:0] pcFetch;
    logic [3:0] opc;
    logic [7:0] opnd;
    logic [7:0] pcNext;
  } expInstr_t;

  typedef struct packed {
    logic [1:0] cmp;
    logic       eq;
    logic       lt;
    logic       gt;
    logic [7:0] pcNext;
  } condCase_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  rom_addr;
  logic [11:0] rom_data = 12'h000;
  logic [3:0]  op_code;
  logic [7:0]  operand;
  logic        jp = 1'b0;
  logic        jpc = 1'b0;
  logic [1:0]  comp = 2'b00;
  logic        flag_eq = 1'b0;
  logic        flag_lt = 1'b0;
  logic        flag_gt = 1'b0;
  logic [7:0]  pc;
  logic        halted;
  logic        retire;

  logic [11:0] rom [256];
  logic [1:0]  cmpSel = 2'b00;
  expInstr_t   expQ[$];
  int          vectors = 0;
  int          miscompares = 0;

  fetch_sequencer #(
    .ADDR_W   (8),
    .OPND_W   (8),
    .RESET_PC (0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .op_code  (op_code),
    .operand  (operand),
    .jp       (jp),
    .jpc      (jpc),
    .comp     (comp),
    .flag_eq  (flag_eq),
    .flag_lt  (flag_lt),
    .flag_gt  (flag_gt),
    .pc       (pc),
    .halted   (halted),
    .retire   (retire)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with one-cycle read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Control unit: registers the decoded opcode, so strobes are valid in exec only.
  always @(posedge clk) begin
    jp   <= (op_code == 4'hB);
    jpc  <= (op_code == 4'hD);
    comp <= (op_code == 4'hD) ? cmpSel : 2'b00;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearRom();
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
  endtask

  task automatic doReset();
    run = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Entered at the sample point of an S_FETCH cycle; leaves at the next S_FETCH.
  task automatic checkInstr(input bit dropRun);
    expInstr_t e;
    if (expQ.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_empty: actual=0 entries required>=1");
      return;
    end
    e = expQ.pop_front();
    vectors++;
    if (rom_addr !== e.pcFetch) begin
      miscompares++;
      $display("FAIL fetch_addr: actual=%h required=%h", rom_addr, e.pcFetch);
    end
    tick();
    if (dropRun) run = 1'b0;
    vectors++;
    if (rom_addr !== e.pcFetch || op_code !== 4'hF) begin
      miscompares++;
      $display("FAIL load_cycle: addr=%h op=%h required addr=%h op=f", rom_addr, op_code, e.pcFetch);
    end
    tick();
    vectors++;
    if (op_code !== e.opc || retire !== 1'b0) begin
      miscompares++;
      $display("FAIL decode_opcode: actual=%h retire=%b required=%h retire=0", op_code, retire, e.opc);
    end
    vectors++;
    if (operand !== e.opnd) begin
      miscompares++;
      $display("FAIL decode_operand: actual=%h required=%h", operand, e.opnd);
    end
    tick();
    vectors++;
    if (retire !== 1'b1 || op_code !== 4'hF || operand !== e.opnd) begin
      miscompares++;
      $display("FAIL exec_cycle: retire=%b op=%h opnd=%h required retire=1 op=f opnd=%h",
               retire, op_code, operand, e.opnd);
    end
    tick();
    vectors++;
    if (pc !== e.pcNext || rom_addr !== e.pcNext || retire !== 1'b0) begin
      miscompares++;
      $display("FAIL next_pc: pc=%h addr=%h retire=%b required pc=%h retire=0",
               pc, rom_addr, retire, e.pcNext);
    end
  endtask

  task automatic test_reset();
    clearRom();
    doReset();
    vectors++;
    if (pc !== 8'h00 || rom_addr !== 8'h00 || op_code !== 4'hF || operand !== 8'h00 ||
        halted !== 1'b0 || retire !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: pc=%h addr=%h op=%h opnd=%h halted=%b retire=%b required 00 00 f 00 0 0",
               pc, rom_addr, op_code, operand, halted, retire);
    end
  endtask

  task automatic test_sequential();
    clearRom();
    rom[0] = 12'h205;
    rom[1] = 12'h307;
    rom[2] = 12'h012;
    doReset();
    run = 1'b1;
    expQ.push_back('{8'h00, 4'h2, 8'h05, 8'h01});
    expQ.push_back('{8'h01, 4'h3, 8'h07, 8'h02});
    expQ.push_back('{8'h02, 4'h0, 8'h12, 8'h03});
    for (int i = 0; i < 3; i++) checkInstr(1'b0);
  endtask

  task automatic test_jump();
    clearRom();
    rom[0]     = 12'hB40;
    rom[8'h40] = 12'h111;
    doReset();
    run = 1'b1;
    expQ.push_back('{8'h00, 4'hB, 8'h40, 8'h40});
    expQ.push_back('{8'h40, 4'h1, 8'h11, 8'h41});
    checkInstr(1'b0);
    checkInstr(1'b0);
  endtask

  task automatic test_cond_jump();
    condCase_t tab[6];
    tab[0] = '{2'b01, 1'b0, 1'b1, 1'b0, 8'h20};
    tab[1] = '{2'b01, 1'b0, 1'b0, 1'b1, 8'h01};
    tab[2] = '{2'b11, 1'b1, 1'b1, 1'b1, 8'h01};
    tab[3] = '{2'b00, 1'b1, 1'b0, 1'b0, 8'h20};
    tab[4] = '{2'b10, 1'b0, 1'b0, 1'b1, 8'h20};
    tab[5] = '{2'b10, 1'b1, 1'b1, 1'b0, 8'h01};
    for (int i = 0; i < 6; i++) begin
      clearRom();
      rom[0] = 12'hD20;
      doReset();
      cmpSel  = tab[i].cmp;
      flag_eq = tab[i].eq;
      flag_lt = tab[i].lt;
      flag_gt = tab[i].gt;
      run = 1'b1;
      expQ.push_back('{8'h00, 4'hD, 8'h20, tab[i].pcNext});
      checkInstr(1'b0);
    end
    flag_eq = 1'b0;
    flag_lt = 1'b0;
    flag_gt = 1'b0;
    cmpSel  = 2'b00;
  endtask

  task automatic test_wrap();
    clearRom();
    rom[0]     = 12'hBFF;
    rom[8'hFF] = 12'h100;
    doReset();
    run = 1'b1;
    expQ.push_back('{8'h00, 4'hB, 8'hFF, 8'hFF});
    expQ.push_back('{8'hFF, 4'h1, 8'h00, 8'h00});
    expQ.push_back('{8'h00, 4'hB, 8'hFF, 8'hFF});
    for (int i = 0; i < 3; i++) checkInstr(1'b0);
  endtask

  task automatic test_halt();
    clearRom();
    rom[0] = 12'h201;
    rom[1] = 12'h202;
    rom[2] = 12'h203;
    rom[3] = 12'hF00;
    doReset();
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expQ.push_back('{i[7:0], 4'h2, 8'(i + 1), 8'(i + 1)});
      checkInstr(1'b0);
    end
    tick();
    tick();
    vectors++;
    if (op_code !== 4'hF || retire !== 1'b0 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_decode: op=%h retire=%b halted=%b required f 0 0", op_code, retire, halted);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (halted !== 1'b1 || pc !== 8'h03 || op_code !== 4'hF || retire !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_hold: halted=%b pc=%h op=%h retire=%b required 1 03 f 0",
                 halted, pc, op_code, retire);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (pc !== 8'h00 || halted !== 1'b0 || op_code !== 4'hF) begin
      miscompares++;
      $display("FAIL halt_exit: pc=%h halted=%b op=%h required 00 0 f", pc, halted, op_code);
    end
  endtask

  task automatic test_run_hold();
    clearRom();
    rom[0] = 12'h205;
    rom[1] = 12'h307;
    doReset();
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (rom_addr !== 8'h00 || op_code !== 4'hF || retire !== 1'b0) begin
        miscompares++;
        $display("FAIL run_low_hold: addr=%h op=%h retire=%b required 00 f 0", rom_addr, op_code, retire);
      end
    end
    run = 1'b1;
    expQ.push_back('{8'h00, 4'h2, 8'h05, 8'h01});
    checkInstr(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (pc !== 8'h01 || rom_addr !== 8'h01 || op_code !== 4'hF) begin
        miscompares++;
        $display("FAIL run_drop_hold: pc=%h addr=%h op=%h required 01 01 f", pc, rom_addr, op_code);
      end
    end
    run = 1'b1;
    expQ.push_back('{8'h01, 4'h3, 8'h07, 8'h02});
    checkInstr(1'b0);
  endtask

  task automatic test_reset_in_exec();
    clearRom();
    rom[0] = 12'hB40;
    doReset();
    run = 1'b1;
    tick();
    tick();
    tick();
    vectors++;
    if (retire !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_exec_reach: retire=%b required 1", retire);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (pc !== 8'h00 || rom_addr !== 8'h00 || operand !== 8'h00 || retire !== 1'b0 || op_code !== 4'hF) begin
      miscompares++;
      $display("FAIL rst_exec_discard: pc=%h addr=%h opnd=%h retire=%b op=%h required 00 00 00 0 f",
               pc, rom_addr, operand, retire, op_code);
    end
    expQ.push_back('{8'h00, 4'hB, 8'h40, 8'h40});
    checkInstr(1'b0);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_cond_jump();
    test_wrap();
    test_halt();
    test_run_hold();
    test_reset_in_exec();
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: actual=%0d entries required=0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
